bcd_sub_sequencer: RTL
======================

# bcd_sub_sequencer

Digit-serial controller that computes the signed difference A − B of two DIGITS-wide packed BCD operands by time-multiplexing one single-digit complement/add unit. Subtraction is done as A + ten's complement of B, one digit per cycle. A second pass through the same unit re-complements negative results into sign-magnitude form. The block sits between operand registers and the display/result path of the BCD arithmetic lab datapath and owns all sequencing of the shared digit unit.

## Interface
Parameters:
- DIGITS, 4, number of BCD digits per operand (≥1)

Ports:
- clk  in  1  rising-edge clock; the single clock for the block
- reset  in  1  synchronous, active-high reset
- start  in  1  request a new subtraction; sampled only in IDLE
- a  in  4*DIGITS  minuend, packed BCD, digit 0 = bits [3:0]
- b  in  4*DIGITS  subtrahend, packed BCD
- busy  out  1  high in RUN and FIX
- done  out  1  one-cycle pulse when a result is valid
- diff  out  4*DIGITS  magnitude of A − B, packed BCD
- negative  out  1  1 when A < B
- invalid  out  1  1 when any input digit > 9

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE with start=1: latch a and b. Clear diff, negative and invalid. Set idx=0 and carry=1.
  - If any digit of a or b is > 9: set invalid=1, leave diff=0, go to DONE.
  - Otherwise go to RUN.
- IDLE with start=0: stay in IDLE. All outputs hold.
- RUN: digit unit inputs are x=a[idx], y=b[idx], cin=carry.
  - s = x + (9 − y) + cin, range 0..19.
  - If s > 9: digit = s − 10 and cout = 1. Otherwise digit = s and cout = 0.
  - Write diff[idx] = digit, update carry = cout, increment idx.
- End of RUN: after the idx=DIGITS−1 cycle:
  - Final carry=1 means A ≥ B: go to DONE with negative=0.
  - Final carry=0 means A < B: set negative=1, reset idx=0 and carry=1, go to FIX.
- FIX: the same unit runs with x=0, y=diff[idx], cin=carry. Write diff[idx] = digit, update carry, increment idx. After the idx=DIGITS−1 cycle, go to DONE. Result is the ten's complement of the RUN result, i.e. |A − B|.
- DONE: done=1 for exactly one cycle, then go to IDLE. diff, negative and invalid hold until the next accepted start.
- start while busy or in DONE is ignored and is not queued.
- Negative zero cannot occur, because A = B always gives final carry 1.
- Modulo behaviour: no overflow is possible. |A − B| ≤ 10^DIGITS − 1.

## Timing
- Reset values: state IDLE, busy=0, done=0, diff=0, negative=0, invalid=0, idx=0, carry=0.
- Reset has priority over every state. Reset asserted mid-RUN or mid-FIX aborts the operation immediately; no done pulse is produced.
- Let edge E be the edge at which start is sampled in IDLE.
  - Invalid input: done is high in the cycle after E.
  - A ≥ B: RUN occupies DIGITS cycles and done is high DIGITS+1 cycles after E.
  - A < B: FIX adds DIGITS cycles and done is high 2·DIGITS+1 cycles after E.
- busy goes high in the cycle after E and drops in the DONE cycle.
- Earliest next accepted start is the cycle after DONE, i.e. with the block back in IDLE.
- The digit unit is purely combinational. diff, negative and carry update only on clock edges.

## Structure
- Package bcd_pkg holds:
  - BCD_W = 4 and BCD_MAX = 9
  - the state enum {IDLE, RUN, FIX, DONE}
  - a bcd_digit_t typedef
- Sub-module bcd_digit_alu is purely combinational:
  - inputs: x[3:0], y[3:0], cin
  - outputs: digit[3:0], cout
  - function: x + (9 − y) + cin with decimal correction
  - Instantiated exactly once and shared by RUN and FIX through an input mux.
- Top-level contents: FSM, idx counter ($clog2(DIGITS) bits, minimum 1), carry flop, operand latches, diff register file, input-validity check.

## Test plan
- DIGITS=4, a=0x0042, b=0x0017 → diff=0x0025, negative=0, invalid=0. done 5 cycles after start edge; busy high for 4 cycles.
- a=0x0017, b=0x0042 → diff=0x0025, negative=1. done 9 cycles after start edge; FIX pass observed.
- Boundaries:
  - a=0x9999, b=0x0000 → 0x9999, negative=0.
  - a=0x0000, b=0x9999 → 0x9999, negative=1.
  - a=b=0x0000 → 0x0000, negative=0.
- a=0x00A1, b=0x0001 → invalid=1, diff=0x0000. done in the cycle after start; busy never asserted.
- Start 0x0017 − 0x0042, assert reset during the 3rd RUN cycle → all outputs 0, no done pulse.
- Back-to-back and ignored starts:
  - Hold start high throughout: a new operation begins in the cycle after each done pulse.
  - start pulses while busy are ignored; latched operands are unchanged.

Source files
------------

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit types, limits and sequencer states
package bcd_pkg;
  localparam int BCD_W = 4;
  localparam int BCD_MAX = 9;
  typedef logic [BCD_W-1:0] bcd_digit_t;
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  function automatic logic is_bcd(input bcd_digit_t d);
    return d <= bcd_digit_t'(BCD_MAX);
  endfunction
endpackage

// File: rtl/bcd_digit_alu.sv
// bcd_digit_alu: one-digit x + (9 - y) + cin with decimal correction
module bcd_digit_alu
  import bcd_pkg::*;
(
  input  bcd_digit_t x,
  input  bcd_digit_t y,
  input  logic       cin,
  output bcd_digit_t digit,
  output logic       cout
);
  logic [4:0] s;
  assign s = {1'b0, x} + {1'b0, bcd_digit_t'(BCD_MAX) - y} + {4'b0, cin};
  assign cout = s > 5'(BCD_MAX);
  assign digit = cout ? 4'(s - 5'd10) : s[3:0];
endmodule

// File: rtl/bcd_sub_sequencer.sv
// bcd_sub_sequencer: digit-serial signed BCD subtraction on one shared digit unit
module bcd_sub_sequencer
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   diff,
  output logic                  negative,
  output logic                  invalid
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  state_t state;
  logic [IW-1:0] idx;
  logic carry, bad, cout, fix, last;
  logic [4*DIGITS-1:0] al, bl;
  bcd_digit_t x, y, digit;
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      bad = bad | !is_bcd(a[i*4 +: 4]) | !is_bcd(b[i*4 +: 4]);
  end
  assign fix = state == FIX;
  assign last = idx == IW'(DIGITS - 1);
  // FIX re-complements the stored RUN result: 0 - diff with the same unit
  assign x = fix ? '0 : al[idx*4 +: 4];
  assign y = fix ? diff[idx*4 +: 4] : bl[idx*4 +: 4];
  bcd_digit_alu u_alu (.x(x), .y(y), .cin(carry), .digit(digit), .cout(cout));
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      diff <= '0;
      negative <= 1'b0;
      invalid <= 1'b0;
      idx <= '0;
      carry <= 1'b0;
      al <= '0;
      bl <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          al <= a;
          bl <= b;
          diff <= '0;
          negative <= 1'b0;
          invalid <= bad;
          idx <= '0;
          carry <= 1'b1;
          busy <= !bad;
          done <= bad;
          state <= bad ? DONE : RUN;
        end
        RUN, FIX: begin
          diff[idx*4 +: 4] <= digit;
          carry <= cout;
          idx <= idx + 1'b1;
          if (last) begin
            if (!fix && !cout) begin
              negative <= 1'b1;
              idx <= '0;
              carry <= 1'b1;
              state <= FIX;
            end else begin
              busy <= 1'b0;
              done <= 1'b1;
              state <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
